// File: rtl/adder_share_arbiter_pkg.sv
// Shared constants and types for the shared-adder round-robin arbiter.
// The tag id field is sized for the largest supported requester count (16).
package adder_share_arbiter_pkg;

    localparam int unsigned ADDER_LATENCY = 2;
    localparam int unsigned TAG_ID_W      = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester, adder and response signals of the shared-adder arbiter.
// The slave modport is the arbiter; master is the parent (requesters plus adder).
interface adder_share_arbiter_if
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = ADDER_LATENCY
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_a;
    logic [N_REQ*DATA_WIDTH-1:0] req_b;
    logic [N_REQ-1:0]            req_ready;
    logic                        add_enable;
    logic [DATA_WIDTH-1:0]       add_a;
    logic [DATA_WIDTH-1:0]       add_b;
    logic [DATA_WIDTH-1:0]       add_sum;
    logic                        add_carry;
    logic [N_REQ-1:0]            rsp_valid;
    logic [ID_W-1:0]             rsp_id;
    logic [DATA_WIDTH-1:0]       rsp_sum;
    logic                        rsp_carry;
    logic [CNT_W-1:0]            inflight;

    modport master (
        output req_valid, req_a, req_b, add_sum, add_carry,
        input  req_ready, add_enable, add_a, add_b,
               rsp_valid, rsp_id, rsp_sum, rsp_carry, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, add_sum, add_carry,
        output req_ready, add_enable, add_a, add_b,
               rsp_valid, rsp_id, rsp_sum, rsp_carry, inflight
    );

endinterface

// File: rtl/adder_share_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping N_REQ-1 -> 0; returns a one-hot grant and its index.
module rr_priority_picker #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [$clog2(N_REQ)-1:0] ptr,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_any
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(ptr) + k) % N_REQ);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external pipelined adder among N_REQ requesters,
// tagging each issued operation and steering the result back to its owner.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = ADDER_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_share_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [N_REQ-1:0]         req_gated;
    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          grant_id;
    logic                     grant_any;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    tag_t [LATENCY-1:0]       tag_q, tag_d;
    tag_t                     tag_new;
    tag_t                     tag_last;
    logic [DATA_WIDTH-1:0]    op_a, op_b;
    logic [CNT_W-1:0]         inflight_cnt;

    assign req_gated = bus.req_valid & {N_REQ{~rst}};

    rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
        .ptr       (ptr_q),
        .req       (req_gated),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any)
            ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        tag_new.valid = grant_any;
        tag_new.id    = TAG_ID_W'(grant_id);
        if (LATENCY > 1)
            tag_d = {tag_q[LATENCY-2:0], tag_new};
        else
            tag_d = tag_new;
    end

    // Operands are zero when nothing is granted so the adder sees no stale data.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                op_a = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                op_b = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned s = 0; s < LATENCY; s++)
            inflight_cnt = inflight_cnt + CNT_W'(tag_q[s].valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            tag_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            tag_q <= tag_d;
        end
    end

    // The last tag stage lines up with the adder output register, so results
    // are forwarded combinationally; strobes are held off while in reset.
    assign tag_last       = tag_q[LATENCY-1];
    assign bus.req_ready  = grant;
    assign bus.add_enable = ~rst;
    assign bus.add_a      = op_a;
    assign bus.add_b      = op_b;
    assign bus.rsp_valid  = (tag_last.valid && !rst) ? (N_REQ'(1) << tag_last.id) : '0;
    assign bus.rsp_id     = ID_W'(tag_last.id);
    assign bus.rsp_sum    = bus.add_sum;
    assign bus.rsp_carry  = bus.add_carry;
    assign bus.inflight   = inflight_cnt;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based arbitration/response model and a 2-stage adder model.
module tb_adder_share_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic clk;
    logic rst;

    adder_share_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .LATENCY(2)) bus ();

    adder_share_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External adder: input register then output register; enable low clears both.
    logic [DW-1:0] s1_a = '0;
    logic [DW-1:0] s1_b = '0;
    logic [DW:0]   s2   = '0;
    always @(posedge clk) begin
        if (!bus.add_enable) begin
            s1_a <= '0;
            s1_b <= '0;
            s2   <= '0;
        end else begin
            s1_a <= bus.add_a;
            s1_b <= bus.add_b;
            s2   <= {1'b0, s1_a} + {1'b0, s1_b};
        end
    end
    assign bus.add_sum   = s2[DW-1:0];
    assign bus.add_carry = s2[DW];

    typedef struct {
        int         id;
        logic [8:0] sum;
        int         due;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    logic [3:0] obs_ready, obs_rsp_valid, exp_ready, exp_rsp_valid;
    logic [7:0] obs_a, obs_b, obs_sum, exp_a, exp_b, exp_sum;
    logic [1:0] obs_rsp_id, obs_inflight;
    logic       obs_carry, obs_en, exp_carry;
    int         exp_rsp_id, exp_inflight;

    // Drive one cycle, sample at the falling edge, and advance the reference model.
    task automatic drive_cycle(input logic r, input logic [3:0] v,
                               input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   i;
        rst           = r;
        bus.req_valid = v;
        bus.req_a     = a;
        bus.req_b     = b;
        @(negedge clk);
        obs_ready     = bus.req_ready;
        obs_a         = bus.add_a;
        obs_b         = bus.add_b;
        obs_en        = bus.add_enable;
        obs_rsp_valid = bus.rsp_valid;
        obs_rsp_id    = bus.rsp_id;
        obs_sum       = bus.rsp_sum;
        obs_carry     = bus.rsp_carry;
        obs_inflight  = bus.inflight;
        exp_inflight  = q.size();
        exp_rsp_valid = '0;
        exp_rsp_id    = 0;
        exp_sum       = '0;
        exp_carry     = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (!r) begin
                exp_rsp_valid = 4'(1 << e.id);
                exp_rsp_id    = e.id;
                exp_sum       = e.sum[7:0];
                exp_carry     = e.sum[8];
            end
        end
        exp_ready = '0;
        exp_a     = '0;
        exp_b     = '0;
        if (r) begin
            q.delete();
            m_ptr = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr + k) % 4;
                if (v[i] && exp_ready == 4'b0000) begin
                    exp_ready[i] = 1'b1;
                    exp_a        = a[i*8 +: 8];
                    exp_b        = b[i*8 +: 8];
                    e.id         = i;
                    e.sum        = {1'b0, exp_a} + {1'b0, exp_b};
                    e.due        = cyc + 2;
                    q.push_back(e);
                    m_ptr = (i + 1) % 4;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 4'b1111, $urandom, $urandom);
        drive_cycle(1'b1, 4'b1111, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
        n_cmp++; if (obs_en !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", obs_en); end
        n_cmp++; if (obs_rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", obs_rsp_valid); end
        n_cmp++; if (obs_a !== 8'h00 || obs_b !== 8'h00) begin n_fail++; $display("FAIL reset_operands: got %h/%h want 00/00", obs_a, obs_b); end
        drive_cycle(1'b0, 4'b0000, $urandom, $urandom);
        n_cmp++; if (obs_en !== 1'b1) begin n_fail++; $display("FAIL release_enable: got %b want 1", obs_en); end
        n_cmp++; if (obs_rsp_id !== 2'd0 || obs_sum !== 8'h00 || obs_carry !== 1'b0) begin n_fail++; $display("FAIL release_rsp: got id=%0d sum=%h c=%b want 0/00/0", obs_rsp_id, obs_sum, obs_carry); end
        n_cmp++; if (obs_inflight !== 2'd0) begin n_fail++; $display("FAIL release_inflight: got %0d want 0", obs_inflight); end
    endtask

    task automatic test_single();
        drive_cycle(1'b0, 4'b0001, 32'h0000_000F, 32'h0000_0001);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", obs_ready); end
        n_cmp++; if (obs_a !== 8'h0F || obs_b !== 8'h01) begin n_fail++; $display("FAIL single_operands: got %h/%h want 0f/01", obs_a, obs_b); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_rsp_valid !== 4'b0000 || obs_inflight !== 2'd1) begin n_fail++; $display("FAIL single_wait: got rv=%b infl=%0d want 0000/1", obs_rsp_valid, obs_inflight); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_rsp_valid !== 4'b0001 || obs_rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp: got rv=%b id=%0d want 0001/0", obs_rsp_valid, obs_rsp_id); end
        n_cmp++; if (obs_sum !== 8'h10 || obs_carry !== 1'b0) begin n_fail++; $display("FAIL single_sum: got %h c=%b want 10/0", obs_sum, obs_carry); end
    endtask

    task automatic test_overflow();
        drive_cycle(1'b0, 4'b0100, 32'h00FF_0000, 32'h0002_0000);
        n_cmp++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL ovf_ready: got %b want 0100", obs_ready); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_rsp_valid !== 4'b0100 || obs_rsp_id !== 2'd2) begin n_fail++; $display("FAIL ovf_rsp: got rv=%b id=%0d want 0100/2", obs_rsp_valid, obs_rsp_id); end
        n_cmp++; if (obs_sum !== 8'h01 || obs_carry !== 1'b1) begin n_fail++; $display("FAIL ovf_sum: got %h c=%b want 01/1", obs_sum, obs_carry); end
    endtask

    task automatic test_round_robin();
        drive_cycle(1'b1, 4'b0000, 32'h0, 32'h0);
        for (int k = 0; k < 12; k++) begin
            drive_cycle(1'b0, 4'b1111, $urandom, $urandom);
            n_cmp++; if (obs_ready !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, obs_ready, 4'(1 << (k % 4))); end
            if (k >= 2) begin
                n_cmp++; if (obs_rsp_valid !== 4'(1 << ((k - 2) % 4)) || obs_rsp_id !== 2'((k - 2) % 4)) begin n_fail++; $display("FAIL rr_rsp[%0d]: got rv=%b id=%0d want id %0d", k, obs_rsp_valid, obs_rsp_id, (k - 2) % 4); end
                n_cmp++; if (obs_sum !== exp_sum || obs_carry !== exp_carry) begin n_fail++; $display("FAIL rr_sum[%0d]: got %h/%b want %h/%b", k, obs_sum, obs_carry, exp_sum, exp_carry); end
                n_cmp++; if (obs_inflight !== 2'd2) begin n_fail++; $display("FAIL rr_inflight[%0d]: got %0d want 2", k, obs_inflight); end
            end
        end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_pointer_skip();
        drive_cycle(1'b0, 4'b0001, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_setup: got %b want 0001", obs_ready); end
        drive_cycle(1'b0, 4'b1001, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_first: got %b want 1000", obs_ready); end
        drive_cycle(1'b0, 4'b1001, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_wrap: got %b want 0001", obs_ready); end
        drive_cycle(1'b0, 4'b0011, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_ptr_end: got %b want 0010", obs_ready); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_reset_midflight();
        drive_cycle(1'b0, 4'b0010, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL mid_grant1: got %b want 0010", obs_ready); end
        drive_cycle(1'b0, 4'b0100, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL mid_grant2: got %b want 0100", obs_ready); end
        drive_cycle(1'b1, 4'b1111, $urandom, $urandom);
        n_cmp++; if (obs_rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rsp: got %b want 0000", obs_rsp_valid); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_rsp_valid !== 4'b0000 || obs_inflight !== 2'd0) begin n_fail++; $display("FAIL mid_after1: got rv=%b infl=%0d want 0000/0", obs_rsp_valid, obs_inflight); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        n_cmp++; if (obs_rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_after2: got %b want 0000", obs_rsp_valid); end
        drive_cycle(1'b0, 4'b1111, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", obs_ready); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_idle();
        drive_cycle(1'b0, 4'b0100, $urandom, $urandom);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b0, 4'b0000, $urandom, $urandom);
            n_cmp++; if (obs_a !== 8'h00 || obs_b !== 8'h00 || obs_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ops[%0d]: got a=%h b=%h rdy=%b want 00/00/0000", k, obs_a, obs_b, obs_ready); end
            n_cmp++; if (obs_rsp_valid !== 4'b0000 || obs_inflight !== 2'd0) begin n_fail++; $display("FAIL idle_rsp[%0d]: got rv=%b infl=%0d want 0000/0", k, obs_rsp_valid, obs_inflight); end
        end
        drive_cycle(1'b0, 4'b1111, $urandom, $urandom);
        n_cmp++; if (obs_ready !== 4'b1000) begin n_fail++; $display("FAIL idle_ptr_kept: got %b want 1000", obs_ready); end
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
        drive_cycle(1'b0, 4'b0000, 32'h0, 32'h0);
    endtask

    task automatic test_random();
        logic r;
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 39) == 0);
            drive_cycle(r, 4'($urandom_range(0, 15)), $urandom, $urandom);
            n_cmp++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, obs_ready, exp_ready); end
            n_cmp++; if (obs_a !== exp_a || obs_b !== exp_b) begin n_fail++; $display("FAIL rnd_ops[%0d]: got %h/%h want %h/%h", k, obs_a, obs_b, exp_a, exp_b); end
            n_cmp++; if (obs_en !== !r) begin n_fail++; $display("FAIL rnd_enable[%0d]: got %b want %b", k, obs_en, !r); end
            n_cmp++; if (obs_rsp_valid !== exp_rsp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", k, obs_rsp_valid, exp_rsp_valid); end
            n_cmp++; if (obs_inflight !== 2'(exp_inflight)) begin n_fail++; $display("FAIL rnd_inflight[%0d]: got %0d want %0d", k, obs_inflight, exp_inflight); end
            if (exp_rsp_valid != 4'b0000) begin
                n_cmp++; if (obs_rsp_id !== 2'(exp_rsp_id) || obs_sum !== exp_sum || obs_carry !== exp_carry) begin n_fail++; $display("FAIL rnd_rsp[%0d]: got id=%0d %h/%b want id=%0d %h/%b", k, obs_rsp_id, obs_sum, obs_carry, exp_rsp_id, exp_sum, exp_carry); end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_pointer_skip();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
